// File: rtl/add32_rr_sched.sv
`default_nettype none
// ============================================================================
// add32_rr_sched : round-robin scheduler sharing one pipelined adder among
//                  NREQ requesters, routing each result back to its originator
// Revision       : 1.0
// ============================================================================

module add32_rr_sched #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int LAT  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    output logic              add_cin,
    input  logic [W-1:0]      add_sum,
    input  logic              add_cout,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    input  logic              quiesce,
    output logic              idle
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [LAT:0]          tag_vld_q, tag_vld_d;
    logic [LAT:0][IDW-1:0] tag_id_q, tag_id_d;
    logic [W-1:0]          add_a_q, add_a_d;
    logic [W-1:0]          add_b_q, add_b_d;
    logic                  add_cin_q, add_cin_d;
    logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic [W-1:0]          rsp_sum_q, rsp_sum_d;
    logic                  rsp_cout_q, rsp_cout_d;

    logic                  grant_en;
    logic                  grant;
    logic [IDW-1:0]        grant_idx;
    logic [IDW-1:0]        cand;
    logic                  pipe_empty;

    assign pipe_empty = ~|tag_vld_q;
    // quiesce masks the grant combinationally, even before the FSM leaves RUN
    assign grant_en   = (state_q == ST_RUN) && !quiesce;

    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = IDW'((int'(ptr_q) + off) % NREQ);
            if (grant_en && !grant && req_valid[cand]) begin
                grant     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (quiesce) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!quiesce)        state_d = ST_RUN;
                else if (pipe_empty) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (!quiesce) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_cin_d = add_cin_q;
        if (grant) begin
            ptr_d     = grant_idx;
            add_a_d   = req_a[int'(grant_idx)*W +: W];
            add_b_d   = req_b[int'(grant_idx)*W +: W];
            add_cin_d = req_cin[grant_idx];
        end
    end

    // Entry 0 is this cycle's grant; entry LAT lines up with the adder output.
    always_comb begin
        tag_vld_d   = {tag_vld_q[LAT-1:0], grant};
        tag_id_d    = tag_id_q;
        tag_id_d[0] = grant_idx;
        for (int j = 1; j <= LAT; j++) begin
            tag_id_d[j] = tag_id_q[j-1];
        end
    end

    always_comb begin
        rsp_valid_d = '0;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        if (tag_vld_q[LAT]) begin
            rsp_valid_d[tag_id_q[LAT]] = 1'b1;
            rsp_sum_d                  = add_sum;
            rsp_cout_d                 = add_cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            ptr_q       <= IDW'(NREQ - 1);
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign idle      = pipe_empty && ((state_q != ST_RUN) || (req_valid == '0));

endmodule

`default_nettype wire

// File: tb/tb_add32_rr_sched.sv
`default_nettype none
// ============================================================================
// tb_add32_rr_sched : scenario tests plus a scoreboard monitor for the
//                     round-robin adder scheduler
// Revision          : 1.0
// ============================================================================

module tb_add32_rr_sched;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int LAT  = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic [NREQ-1:0]   req_cin = '0;
    logic [NREQ-1:0]   req_ready;
    logic [W-1:0]      add_a, add_b;
    logic              add_cin;
    logic [W-1:0]      add_sum;
    logic              add_cout;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic              quiesce = 1'b0;
    logic              idle;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    add32_rr_sched #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .req_ready(req_ready),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .quiesce(quiesce), .idle(idle)
    );

    // Behavioural adder: result of the operands registered at edge k appears after edge k+LAT
    logic [W:0] apipe [LAT] = '{default: '0};
    always @(posedge clk) begin
        apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
        for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign add_sum  = apipe[LAT-1][W-1:0];
    assign add_cout = apipe[LAT-1][W];

    // Reference model: expected responses with the sample index at which each must appear
    localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;
    typedef struct {
        int         id;
        logic [W:0] res;
        int         due;
    } exp_t;
    exp_t sb[$];
    int   m_last = NREQ - 1;
    int   m_mode = M_RUN;
    int   ncount = 0;

    always @(negedge clk) begin : monitor
        logic [NREQ-1:0] e_rsp, e_rdy;
        logic            e_idle;
        int              gid;
        exp_t            ne;
        if (!rst_n) begin
            sb.delete();
            m_last = NREQ - 1;
            m_mode = M_RUN;
        end else begin
            ncount++;
            e_rsp = '0;
            if (sb.size() > 0 && sb[0].due == ncount) e_rsp[sb[0].id] = 1'b1;
            n_tests++;
            if (rsp_valid !== e_rsp) begin
                n_fail++;
                $display("FAIL mon_rsp_valid t=%0t: got %b expected %b", $time, rsp_valid, e_rsp);
            end
            if (e_rsp != '0) begin
                n_tests++;
                if ({rsp_cout, rsp_sum} !== sb[0].res) begin
                    n_fail++;
                    $display("FAIL mon_rsp_data t=%0t: got %h expected %h", $time, {rsp_cout, rsp_sum}, sb[0].res);
                end
                ne = sb.pop_front();
            end
            e_rdy = '0;
            gid   = -1;
            if (m_mode == M_RUN && !quiesce) begin
                for (int off = 1; off <= NREQ; off++) begin
                    if (gid < 0 && req_valid[(m_last + off) % NREQ]) gid = (m_last + off) % NREQ;
                end
            end
            if (gid >= 0) e_rdy[gid] = 1'b1;
            n_tests++;
            if (req_ready !== e_rdy) begin
                n_fail++;
                $display("FAIL mon_req_ready t=%0t: got %b expected %b", $time, req_ready, e_rdy);
            end
            e_idle = (sb.size() == 0) && (m_mode != M_RUN || req_valid == '0);
            n_tests++;
            if (idle !== e_idle) begin
                n_fail++;
                $display("FAIL mon_idle t=%0t: got %b expected %b", $time, idle, e_idle);
            end
            case (m_mode)
                M_RUN:   if (quiesce) m_mode = M_DRAIN;
                M_DRAIN: if (!quiesce) m_mode = M_RUN; else if (sb.size() == 0) m_mode = M_HALT;
                default: if (!quiesce) m_mode = M_RUN;
            endcase
            if (gid >= 0) begin
                ne.id  = gid;
                ne.res = {1'b0, req_a[gid*W +: W]} + {1'b0, req_b[gid*W +: W]} + {{W{1'b0}}, req_cin[gid]};
                ne.due = ncount + LAT + 2;
                sb.push_back(ne);
                m_last = gid;
            end
        end
    end

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = c;
    endtask

    task automatic set_rand(input int i);
        set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        quiesce   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req_a = '0; req_b = '0; req_cin = '0;
        do_reset();
        @(negedge clk);
        n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        n_tests++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
        n_tests++; if ({add_cin, add_a, add_b} !== '0) begin n_fail++; $display("FAIL reset_add_ops: got %h/%h/%b expected 0", add_a, add_b, add_cin); end
        n_tests++; if ({rsp_cout, rsp_sum} !== '0) begin n_fail++; $display("FAIL reset_rsp_data: got %h expected 0", {rsp_cout, rsp_sum}); end
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", idle); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        set_req(0, 32'd5, 32'd7, 1'b1);
        req_valid = 4'b0001;
        @(negedge clk);
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        for (int e = 0; e <= 6; e++) begin
            @(negedge clk);
            if (e < 6) begin
                n_tests++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_early e=%0d: got %b expected 0000", e, rsp_valid); end
            end else begin
                n_tests++; if (rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL single_rsp_valid: got %b expected 0001", rsp_valid); end
                n_tests++; if ({rsp_cout, rsp_sum} !== {1'b0, 32'd13}) begin n_fail++; $display("FAIL single_rsp_data: got %b/%0d expected 0/13", rsp_cout, rsp_sum); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap();
        int rc = 0;
        set_req(0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        req_valid = 4'b0001;
        @(posedge clk); #1;
        set_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk); #1;
        req_valid = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                if (rc == 0) begin
                    n_tests++; if ({rsp_cout, rsp_sum} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL wrap_first: got %b/%h expected 1/00000000", rsp_cout, rsp_sum); end
                end else if (rc == 1) begin
                    n_tests++; if ({rsp_cout, rsp_sum} !== {1'b1, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL wrap_second: got %b/%h expected 1/ffffffff", rsp_cout, rsp_sum); end
                end
                rc++;
            end
            @(posedge clk); #1;
        end
        n_tests++; if (rc != 2) begin n_fail++; $display("FAIL wrap_count: got %0d responses expected 2", rc); end
    endtask

    task automatic test_all4();
        localparam int N = 12;
        logic [NREQ-1:0] e;
        do_reset();
        for (int r = 0; r < NREQ; r++) set_rand(r);
        req_valid = '1;
        for (int i = 0; i <= N + LAT + 2; i++) begin
            @(negedge clk);
            if (i < N) begin
                e = '0; e[i % NREQ] = 1'b1;
                n_tests++; if (req_ready !== e) begin n_fail++; $display("FAIL all4_grant i=%0d: got %b expected %b", i, req_ready, e); end
            end
            e = '0;
            if (i >= LAT + 2 && i < LAT + 2 + N) e[(i - LAT - 2) % NREQ] = 1'b1;
            n_tests++; if (rsp_valid !== e) begin n_fail++; $display("FAIL all4_rsp i=%0d: got %b expected %b", i, rsp_valid, e); end
            @(posedge clk); #1;
            if (i < N - 1) begin
                for (int r = 0; r < NREQ; r++) set_rand(r);
            end else begin
                req_valid = '0;
            end
        end
    endtask

    task automatic test_rr_join();
        do_reset();
        set_rand(2);
        req_valid = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL solo_grant i=%0d: got %b expected 0100", i, req_ready); end
            @(posedge clk); #1;
            set_rand(2);
        end
        set_rand(1);
        req_valid = 4'b0110;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_tests++;
            if (req_ready !== ((i % 2 == 0) ? 4'b0010 : 4'b0100)) begin
                n_fail++;
                $display("FAIL join_grant i=%0d: got %b expected %b", i, req_ready, (i % 2 == 0) ? 4'b0010 : 4'b0100);
            end
            @(posedge clk); #1;
            set_rand(1); set_rand(2);
        end
        req_valid = '0;
        idle_cycles(2 * LAT + 4);
    endtask

    task automatic test_quiesce();
        int rc = 0;
        for (int i = 0; i < 3; i++) begin
            set_rand(3);
            req_valid = 4'b1000;
            @(negedge clk);
            n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL q_issue i=%0d: got %b expected 1000", i, req_ready); end
            @(posedge clk); #1;
        end
        for (int r = 0; r < NREQ; r++) set_rand(r);
        quiesce   = 1'b1;
        req_valid = '1;
        for (int c = 0; c < 20 && rc < 3; c++) begin
            @(negedge clk);
            n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL q_no_grant c=%0d: got %b expected 0000", c, req_ready); end
            if (rsp_valid != '0) rc++;
            @(posedge clk); #1;
        end
        n_tests++; if (rc != 3) begin n_fail++; $display("FAIL q_drain_count: got %0d expected 3", rc); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL q_halt_idle c=%0d: got %b expected 1", c, idle); end
            n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL q_halt_ready c=%0d: got %b expected 0000", c, req_ready); end
            @(posedge clk); #1;
        end
        quiesce = 1'b0;
        @(negedge clk);
        n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL q_release_first: got %b expected 0000", req_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL q_resume: got %b expected 0001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        idle_cycles(2 * LAT + 4);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < NREQ; r++) set_req(r, $urandom | 32'h1, $urandom | 32'h1, 1'b1);
            req_valid = '1;
            @(posedge clk); #1;
        end
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        n_tests++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rmid_rsp_valid: got %b expected 0000", rsp_valid); end
        n_tests++; if ({add_cin, add_a, add_b} !== '0) begin n_fail++; $display("FAIL rmid_add_ops: got %h/%h/%b expected 0", add_a, add_b, add_cin); end
        n_tests++; if ({rsp_cout, rsp_sum} !== '0) begin n_fail++; $display("FAIL rmid_rsp_data: got %h expected 0", {rsp_cout, rsp_sum}); end
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rmid_idle: got %b expected 1", idle); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 2 * LAT; c++) begin
            @(negedge clk);
            n_tests++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rmid_ghost c=%0d: got %b expected 0000", c, rsp_valid); end
            n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rmid_post_idle c=%0d: got %b expected 1", c, idle); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_all4();
        test_rr_join();
        test_quiesce();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
